// File: rtl/control_sequencer.sv
// Sequential half of the control unit: one-hot state register, instruction register,
// memory stall, halt hold and illegal-opcode trap. Optional retire counter: CONTROL_SEQUENCER_RETIRE_COUNT_EN.
//
// state        | meaning
// -------------+----------------------------------------------
// ST_FETCH     | fetch instruction (mem_req, wait for mem_ack)
// ST_DECODE    | decode; opc1/opc2 valid
// ST_UOP_OPND  | microop operand
// ST_UOP_EXEC  | microop execute
// ST_MEM_OPND  | memory operand
// ST_MEM_EXEC  | memory access (mem_req, wait for mem_ack)
// ST_JMP_OPND  | jump operand
// ST_JMP_EXEC  | jump execute
// ST_SET_OPND  | set-constant operand
// ST_SET_EXEC  | set-constant execute
// ST_LINK_PC   | link PC
// ST_CALL_LINK | call link
// ST_UPDATE_PC | update PC; retire point, halt hold, trap target
module control_sequencer #(
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [12:0]   nextstate,
    input  logic [IW-1:0] instr,
    input  logic          mem_ack,
    input  logic          halt,
    output logic [12:0]   state,
    output logic          opc1,
    output logic [3:0]    opc2,
    output logic [IW-1:0] ir,
    output logic          mem_req,
    output logic          halted,
    output logic          illegal,
    output logic [7:0]    illegal_cnt,
    output logic [31:0]   retired
);

    typedef enum logic [12:0] {
        ST_FETCH     = 13'h0001,
        ST_DECODE    = 13'h0002,
        ST_UOP_OPND  = 13'h0004,
        ST_UOP_EXEC  = 13'h0008,
        ST_MEM_OPND  = 13'h0010,
        ST_MEM_EXEC  = 13'h0020,
        ST_JMP_OPND  = 13'h0040,
        ST_JMP_EXEC  = 13'h0080,
        ST_SET_OPND  = 13'h0100,
        ST_SET_EXEC  = 13'h0200,
        ST_LINK_PC   = 13'h0400,
        ST_CALL_LINK = 13'h0800,
        ST_UPDATE_PC = 13'h1000
    } state_e;

    logic [12:0] state_q;
    logic [12:0] state_d;
    logic        legal_ns;
    logic        stall;
    logic        hold;
    logic        trap;

    assign mem_req = state_q[0] | state_q[5];
    assign halted  = state_q[12] & halt;
    assign state   = state_q;
    assign opc1    = ir[IW-1];
    assign opc2    = ir[IW-2:IW-5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Stall and halt both freeze the register and suppress the trap check.
    always_comb begin
        state_d  = state_q;
        trap     = 1'b0;
        legal_ns = (nextstate != 13'd0) && ((nextstate & (nextstate - 13'd1)) == 13'd0);
        stall    = mem_req & ~mem_ack;
        hold     = state_q[12] & halt;
        if (!stall && !hold) begin
            if (legal_ns) begin
                state_d = nextstate;
            end else begin
                state_d = ST_UPDATE_PC;
                trap    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir          <= '0;
            illegal     <= 1'b0;
            illegal_cnt <= 8'd0;
        end else begin
            if (state_q[0] && mem_ack) begin
                ir <= instr;
            end
            illegal <= trap;
            if (trap && illegal_cnt != 8'hFF) begin
                illegal_cnt <= illegal_cnt + 8'd1;
            end
        end
    end

`ifdef CONTROL_SEQUENCER_RETIRE_COUNT_EN
    logic        retire;
    logic [31:0] retired_q;

    assign retire  = state_q[12] & ~halt;
    assign retired = retired_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= 32'd0;
        end else if (retire) begin
            retired_q <= retired_q + 32'd1;
        end
    end
`else
    assign retired = 32'd0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer: reset, microop, stall, trap,
// halt and asynchronous reset scenarios with hand-computed expectations.
module tb_control_sequencer;

    logic        clk;
    logic        rst;
    logic [12:0] nextstate;
    logic [31:0] instr;
    logic        mem_ack;
    logic        halt;
    logic [12:0] state;
    logic        opc1;
    logic [3:0]  opc2;
    logic [31:0] ir;
    logic        mem_req;
    logic        halted;
    logic        illegal;
    logic [7:0]  illegal_cnt;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_ret = 32'd0;

`ifdef CONTROL_SEQUENCER_RETIRE_COUNT_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    control_sequencer #(.IW(32)) dut (
        .clk(clk), .rst(rst), .nextstate(nextstate), .instr(instr), .mem_ack(mem_ack),
        .halt(halt), .state(state), .opc1(opc1), .opc2(opc2), .ir(ir), .mem_req(mem_req),
        .halted(halted), .illegal(illegal), .illegal_cnt(illegal_cnt), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ret_exp();
        return RC ? exp_ret : 32'd0;
    endfunction

    task automatic test_reset();
        rst = 1'b1; mem_ack = 1'b0; halt = 1'b0; nextstate = 13'h0002; instr = 32'hDEAD_BEEF;
        #12;
        checks++; if (state !== 13'h0001) begin errors++; $display("FAIL reset_state got=%h exp=%h", state, 13'h0001); end
        checks++; if (ir !== 32'd0) begin errors++; $display("FAIL reset_ir got=%h exp=0", ir); end
        checks++; if ({opc1, opc2} !== 5'd0) begin errors++; $display("FAIL reset_opc got=%b exp=0", {opc1, opc2}); end
        checks++; if ({mem_req, halted, illegal} !== 3'b100) begin errors++; $display("FAIL reset_flags got=%b exp=100", {mem_req, halted, illegal}); end
        checks++; if (illegal_cnt !== 8'd0 || retired !== 32'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", illegal_cnt, retired); end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (state !== 13'h0001 || mem_req !== 1'b1) begin errors++; $display("FAIL fetch_wait%0d got=%h/%b exp=0001/1", i, state, mem_req); end
        end
        mem_ack = 1'b1; instr = 32'h1234_5678;
        step();
        checks++; if (state !== 13'h0002) begin errors++; $display("FAIL fetch_done_state got=%h exp=0002", state); end
        checks++; if (ir !== 32'h1234_5678) begin errors++; $display("FAIL fetch_ir got=%h exp=12345678", ir); end
        checks++; if (opc1 !== 1'b0 || opc2 !== 4'h2) begin errors++; $display("FAIL decode_opc got=%b/%h exp=0/2", opc1, opc2); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL decode_memreq got=%b exp=0", mem_req); end
    endtask

    task automatic test_microop();
        logic [12:0] path [4] = '{13'h0004, 13'h0008, 13'h1000, 13'h0001};
        instr = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            nextstate = path[i];
            if (i == 3) exp_ret++;
            step();
            checks++; if (state !== path[i]) begin errors++; $display("FAIL uop_path%0d got=%h exp=%h", i, state, path[i]); end
        end
        checks++; if (ir !== 32'h1234_5678) begin errors++; $display("FAIL uop_ir_hold got=%h exp=12345678", ir); end
        checks++; if (retired !== ret_exp()) begin errors++; $display("FAIL uop_retired got=%0d exp=%0d", retired, ret_exp()); end
        instr = 32'hA000_0000; nextstate = 13'h0002;
        step();
        checks++; if (opc1 !== 1'b1 || opc2 !== 4'h4) begin errors++; $display("FAIL uop_opc2 got=%b/%h exp=1/4", opc1, opc2); end
    endtask

    task automatic test_stall();
        mem_ack = 1'b0; nextstate = 13'h0010;
        step();
        checks++; if (state !== 13'h0010) begin errors++; $display("FAIL stall_ack_ignored got=%h exp=0010", state); end
        nextstate = 13'h0020;
        step();
        checks++; if (state !== 13'h0020) begin errors++; $display("FAIL stall_enter got=%h exp=0020", state); end
        for (int i = 0; i < 4; i++) begin
            nextstate = (i < 2) ? 13'h0000 : 13'h1000;
            step();
            checks++; if (state !== 13'h0020 || mem_req !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got=%h/%b exp=0020/1", i, state, mem_req); end
            checks++; if (illegal !== 1'b0 || illegal_cnt !== 8'd0) begin errors++; $display("FAIL stall_notrap%0d got=%b/%0d exp=0/0", i, illegal, illegal_cnt); end
        end
        mem_ack = 1'b1; instr = 32'h5555_5555;
        step();
        checks++; if (state !== 13'h1000) begin errors++; $display("FAIL stall_release got=%h exp=1000", state); end
        checks++; if (ir !== 32'hA000_0000) begin errors++; $display("FAIL stall_ir_hold got=%h exp=a0000000", ir); end
        nextstate = 13'h0001; exp_ret++;
        step();
        checks++; if (state !== 13'h0001) begin errors++; $display("FAIL stall_to_fetch got=%h exp=0001", state); end
    endtask

    task automatic test_illegal();
        mem_ack = 1'b1; nextstate = 13'h0002;
        step();
        mem_ack = 1'b0; nextstate = 13'h0000;
        step();
        checks++; if (state !== 13'h1000 || illegal !== 1'b1 || illegal_cnt !== 8'd1) begin errors++; $display("FAIL trap_zero got=%h/%b/%0d exp=1000/1/1", state, illegal, illegal_cnt); end
        nextstate = 13'h0001; exp_ret++;
        step();
        checks++; if (state !== 13'h0001 || illegal !== 1'b0) begin errors++; $display("FAIL trap_pulse_end got=%h/%b exp=0001/0", state, illegal); end
        mem_ack = 1'b1; nextstate = 13'h0002;
        step();
        nextstate = 13'h0014;
        step();
        checks++; if (state !== 13'h1000 || illegal !== 1'b1 || illegal_cnt !== 8'd2) begin errors++; $display("FAIL trap_multi got=%h/%b/%0d exp=1000/1/2", state, illegal, illegal_cnt); end
        nextstate = 13'h0001; exp_ret++;
        step();
        nextstate = 13'h0000;
        for (int i = 1; i <= 300; i++) begin
            if (i >= 2) exp_ret++;
            step();
            if (i == 252) begin
                checks++; if (illegal_cnt !== 8'd254) begin errors++; $display("FAIL trap_cnt254 got=%0d exp=254", illegal_cnt); end
            end
            if (i == 253) begin
                checks++; if (illegal_cnt !== 8'd255) begin errors++; $display("FAIL trap_cnt255 got=%0d exp=255", illegal_cnt); end
            end
        end
        checks++; if (illegal_cnt !== 8'd255 || illegal !== 1'b1 || state !== 13'h1000) begin errors++; $display("FAIL trap_saturate got=%0d/%b/%h exp=255/1/1000", illegal_cnt, illegal, state); end
        checks++; if (retired !== ret_exp()) begin errors++; $display("FAIL trap_retired got=%0d exp=%0d", retired, ret_exp()); end
        nextstate = 13'h0001; exp_ret++;
        step();
        checks++; if (state !== 13'h0001 || illegal !== 1'b0 || illegal_cnt !== 8'd255) begin errors++; $display("FAIL trap_exit got=%h/%b/%0d exp=0001/0/255", state, illegal, illegal_cnt); end
    endtask

    task automatic test_halt();
        logic [12:0] path [4] = '{13'h0002, 13'h0400, 13'h0800, 13'h1000};
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nextstate = path[i];
            if (i == 3) halt = 1'b1;
            step();
            checks++; if (state !== path[i]) begin errors++; $display("FAIL link_path%0d got=%h exp=%h", i, state, path[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            nextstate = (i == 1) ? 13'h0000 : 13'h0001;
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag%0d got=%b exp=1", i, halted); end
            step();
            checks++; if (state !== 13'h1000 || illegal !== 1'b0) begin errors++; $display("FAIL halt_hold%0d got=%h/%b exp=1000/0", i, state, illegal); end
        end
        checks++; if (retired !== ret_exp()) begin errors++; $display("FAIL halt_noretire got=%0d exp=%0d", retired, ret_exp()); end
        halt = 1'b0; nextstate = 13'h0001; exp_ret++;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_release_flag got=%b exp=0", halted); end
        step();
        checks++; if (state !== 13'h0001 || retired !== ret_exp()) begin errors++; $display("FAIL halt_release got=%h/%0d exp=0001/%0d", state, retired, ret_exp()); end
    endtask

    task automatic test_async_reset();
        logic [12:0] path [3] = '{13'h0002, 13'h0010, 13'h0020};
        mem_ack = 1'b1; instr = 32'h0F0F_0F0F;
        for (int i = 0; i < 3; i++) begin
            nextstate = path[i];
            step();
        end
        mem_ack = 1'b0; nextstate = 13'h1000;
        step();
        step();
        checks++; if (state !== 13'h0020 || ir !== 32'h0F0F_0F0F) begin errors++; $display("FAIL arst_pre got=%h/%h exp=0020/0f0f0f0f", state, ir); end
        #2 rst = 1'b1;
        #1;
        checks++; if (state !== 13'h0001 || ir !== 32'd0 || mem_req !== 1'b1) begin errors++; $display("FAIL arst_state got=%h/%h/%b exp=0001/0/1", state, ir, mem_req); end
        checks++; if (illegal_cnt !== 8'd0 || retired !== 32'd0 || illegal !== 1'b0) begin errors++; $display("FAIL arst_counts got=%0d/%0d/%b exp=0/0/0", illegal_cnt, retired, illegal); end
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_microop();
        test_stall();
        test_illegal();
        test_halt();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
